// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the memory stage and its sub-module.
//   mem_state_t : data-memory access state (IDLE, BUSY)
//   m_bundle_t  : fields captured in the EX/MEM pipeline register
//   XLEN        : datapath width
//   REG_RA      : link register index (jal destination)
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] b;
        logic [4:0]      rn;
        logic            wreg;
        logic            m2reg;
        logic            wmem;
    } m_bundle_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus.
//   req   : request valid (master -> slave)
//   we    : 1 = write, 0 = read
//   addr  : word-aligned byte address
//   wdata : store data
//   ready : slave accepts/completes the request this cycle
//   rdata : read data, valid together with ready
// Modports: master (memory stage side), slave (memory side).
interface mem_stage_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/dmem_if_fsm.sv
// dmem_if_fsm: data-memory handshake controller for the memory stage.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   accept       : the stage captures a new instruction this edge
//   mem_op       : the instruction being accepted needs a memory access
//   wmem         : the instruction being accepted is a store
//   dmem_ready   : memory completes the request this cycle
//   dmem_req     : request valid (registered)
//   dmem_we      : request is a write (registered)
//   mstall       : hold the upstream pipeline
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding; no request, no stall
// BUSY  | access outstanding; request held until dmem_ready
module dmem_if_fsm
    import core_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic mem_op,
    input  logic wmem,
    input  logic dmem_ready,
    output logic dmem_req,
    output logic dmem_we,
    output logic mstall
);

    mem_state_t state;
    logic       req_q;
    logic       we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            req_q <= 1'b0;
            we_q  <= 1'b0;
        end else begin
            if (accept && mem_op) begin
                // Also covers the back-to-back case: completion and a new
                // memory op on the same edge keeps us in BUSY.
                state <= BUSY;
                req_q <= 1'b1;
                we_q  <= wmem;
            end else if (state == BUSY && !dmem_ready) begin
                // Hold the request unchanged until the memory responds.
                state <= BUSY;
                req_q <= 1'b1;
                we_q  <= we_q;
            end else begin
                state <= IDLE;
                req_q <= 1'b0;
                we_q  <= 1'b0;
            end
        end
    end

    assign dmem_req = req_q;
    assign dmem_we  = we_q;
    // Stall must see dmem_ready in the same cycle, so it stays combinational.
    assign mstall   = req_q & ~dmem_ready;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the pipelined core. Captures execute results
// into the EX/MEM register, performs the data-memory access over a
// valid/ready bus, stalls upstream while an access is outstanding and
// produces the writeback bundle plus EX/MEM forwarding taps.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   evalid, ealu, eb, ern,
//   ewreg, em2reg, ewmem           : execute-stage instruction
//   mstall                         : upstream must hold its instruction
//   dmem                           : data-memory bus (mem_stage_if.master)
//   mrn, malu, mwreg               : forwarding taps
//   wvalid, wrn, wdata, wwreg      : writeback bundle
//   wexc                           : misaligned-access flag (only with
//                                    MEM_MISALIGN_CHECK_EN defined)
// Build option: MEM_MISALIGN_CHECK_EN turns misaligned loads/stores into
// an exception writeback instead of a memory access.
module mem_stage
    import core_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          evalid,
    input  logic [DW-1:0] ealu,
    input  logic [DW-1:0] eb,
    input  logic [4:0]    ern,
    input  logic          ewreg,
    input  logic          em2reg,
    input  logic          ewmem,
    output logic          mstall,
    mem_stage_if.master   dmem,
    output logic [4:0]    mrn,
    output logic [DW-1:0] malu,
    output logic          mwreg,
    output logic          wvalid,
    output logic [4:0]    wrn,
    output logic [DW-1:0] wdata,
    output logic          wwreg
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic          wexc
`endif
);

    m_bundle_t m;
    logic      m_valid;
    logic      m_misalign;
    logic      accept;
    logic      e_mem;
    logic      e_misalign;
    logic      mem_go;
    logic      w_load;

    assign accept = evalid & ~mstall;
    assign e_mem  = em2reg | ewmem;

`ifdef MEM_MISALIGN_CHECK_EN
    assign e_misalign = e_mem & (ealu[1:0] != 2'b00);
`else
    assign e_misalign = 1'b0;
`endif

    // A misaligned access never reaches the bus.
    assign mem_go = e_mem & ~e_misalign;

    dmem_if_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept),
        .mem_op     (mem_go),
        .wmem       (ewmem),
        .dmem_ready (dmem.ready),
        .dmem_req   (dmem.req),
        .dmem_we    (dmem.we),
        .mstall     (mstall)
    );

    // EX/MEM register. The payload only changes on accept, which keeps the
    // bus address and write data stable while a request waits for ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_misalign <= 1'b0;
            m          <= '0;
        end else if (accept) begin
            m_valid    <= 1'b1;
            m_misalign <= e_misalign;
            m          <= '{alu: ealu, b: eb, rn: ern, wreg: ewreg,
                            m2reg: em2reg, wmem: ewmem};
        end else if (!mstall) begin
            // While stalled the instruction in M is still live.
            m_valid    <= 1'b0;
        end
    end

    assign dmem.addr  = {m.alu[AW-1:2], 2'b00};
    assign dmem.wdata = m.b;

    // Writeback loads unless the access in M is still waiting on memory.
    assign w_load = m_valid & ~mstall;

    always_ff @(posedge clk) begin
        if (rst) begin
            wvalid <= 1'b0;
            wrn    <= '0;
            wdata  <= '0;
            wwreg  <= 1'b0;
        end else if (w_load) begin
            wvalid <= 1'b1;
            wrn    <= m.rn;
            wwreg  <= m.wreg & ~m.wmem & ~m_misalign;
            wdata  <= (m.m2reg && !m_misalign) ? dmem.rdata : m.alu;
        end else begin
            wvalid <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wexc <= 1'b0;
        end else begin
            wexc <= w_load & m_misalign;
        end
    end
`endif

    // Loads are not forwarded from M; load-use is resolved by the hazard unit.
    assign mrn   = m.rn;
    assign malu  = m.alu;
    assign mwreg = m_valid & m.wreg & ~m.m2reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed testbench for mem_stage. Build with
// MEM_MISALIGN_CHECK_EN defined to cover the misaligned-access path.
module tb_mem_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        evalid;
    logic [31:0] ealu;
    logic [31:0] eb;
    logic [4:0]  ern;
    logic        ewreg;
    logic        em2reg;
    logic        ewmem;
    logic        mstall;
    logic [4:0]  mrn;
    logic [31:0] malu;
    logic        mwreg;
    logic        wvalid;
    logic [4:0]  wrn;
    logic [31:0] wdata;
    logic        wwreg;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        wexc;
`endif

    int checks = 0;
    int errors = 0;

    mem_stage_if #(.AW(32), .DW(32)) dmem ();

    mem_stage #(.AW(32), .DW(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .evalid (evalid),
        .ealu   (ealu),
        .eb     (eb),
        .ern    (ern),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .ewmem  (ewmem),
        .mstall (mstall),
        .dmem   (dmem),
        .mrn    (mrn),
        .malu   (malu),
        .mwreg  (mwreg),
        .wvalid (wvalid),
        .wrn    (wrn),
        .wdata  (wdata),
        .wwreg  (wwreg)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .wexc   (wexc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rn, input logic wr, input logic ld, input logic st);
        evalid = v;
        ealu   = a;
        eb     = b;
        ern    = rn;
        ewreg  = wr;
        em2reg = ld;
        ewmem  = st;
    endtask

    task automatic idle_in();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        dmem.ready = 1'b0;
        dmem.rdata = 32'h0;
        step();
        step();
        chk("rst_wvalid", wvalid, 0);
        chk("rst_mstall", mstall, 0);
        chk("rst_req", dmem.req, 0);
        chk("rst_mwreg", mwreg, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wwreg", wwreg, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("rst_wexc", wexc, 0);
`endif
        rst = 1'b0;
        step();

        // ALU op
        drive(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        idle_in();
        chk("alu_m_stall", mstall, 0);
        chk("alu_m_wvalid", wvalid, 0);
        chk("alu_m_mwreg", mwreg, 1);
        chk("alu_m_mrn", mrn, 5);
        chk("alu_m_malu", malu, 32'h1234);
        chk("alu_m_req", dmem.req, 0);
        step();
        chk("alu_w_wvalid", wvalid, 1);
        chk("alu_w_wrn", wrn, 5);
        chk("alu_w_wdata", wdata, 32'h1234);
        chk("alu_w_wwreg", wwreg, 1);
        chk("alu_w_stall", mstall, 0);
        step();
        chk("alu_after_wvalid", wvalid, 0);
        chk("alu_after_wwreg_hold", wwreg, 1);

        // Load with three wait cycles
        drive(1'b1, 32'h40, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            chk("ld_wait_req", dmem.req, 1);
            chk("ld_wait_we", dmem.we, 0);
            chk("ld_wait_addr", dmem.addr, 32'h40);
            chk("ld_wait_stall", mstall, 1);
            chk("ld_wait_wvalid", wvalid, 0);
            chk("ld_wait_mwreg", mwreg, 0);
            step();
        end
        dmem.ready = 1'b1;
        dmem.rdata = 32'hDEADBEEF;
        #1;
        chk("ld_done_req", dmem.req, 1);
        chk("ld_done_addr", dmem.addr, 32'h40);
        chk("ld_done_stall", mstall, 0);
        step();
        dmem.ready = 1'b0;
        dmem.rdata = 32'h0;
        chk("ld_w_wvalid", wvalid, 1);
        chk("ld_w_wdata", wdata, 32'hDEADBEEF);
        chk("ld_w_wwreg", wwreg, 1);
        chk("ld_w_wrn", wrn, 7);
        chk("ld_w_req", dmem.req, 0);
        chk("ld_w_stall", mstall, 0);
        step();

        // Store, ready tied high; ewreg set to show it is masked
        dmem.ready = 1'b1;
        drive(1'b1, 32'h80, 32'hA5A5A5A5, 5'd3, 1'b1, 1'b0, 1'b1);
        step();
        idle_in();
        chk("st_req", dmem.req, 1);
        chk("st_we", dmem.we, 1);
        chk("st_wdata", dmem.wdata, 32'hA5A5A5A5);
        chk("st_addr", dmem.addr, 32'h80);
        chk("st_stall", mstall, 0);
        step();
        chk("st_w_req", dmem.req, 0);
        chk("st_w_wvalid", wvalid, 1);
        chk("st_w_wwreg", wwreg, 0);
        step();

        // Back-to-back load, ALU (jal link into ra), load; ready tied high
        dmem.rdata = 32'h11112222;
        drive(1'b1, 32'h100, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0);
        step();
        chk("b2b_ld1_mwreg", mwreg, 0);
        chk("b2b_ld1_req", dmem.req, 1);
        chk("b2b_ld1_addr", dmem.addr, 32'h100);
        chk("b2b_ld1_stall", mstall, 0);
        drive(1'b1, 32'h55, 32'h0, REG_RA, 1'b1, 1'b0, 1'b0);
        step();
        chk("b2b_w1_wvalid", wvalid, 1);
        chk("b2b_w1_wrn", wrn, 10);
        chk("b2b_w1_wdata", wdata, 32'h11112222);
        chk("b2b_alu_mwreg", mwreg, 1);
        chk("b2b_alu_malu", malu, 32'h55);
        chk("b2b_alu_req", dmem.req, 0);
        dmem.rdata = 32'h33334444;
        drive(1'b1, 32'h104, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0);
        step();
        idle_in();
        chk("b2b_w2_wvalid", wvalid, 1);
        chk("b2b_w2_wrn", wrn, 31);
        chk("b2b_w2_wdata", wdata, 32'h55);
        chk("b2b_ld2_mwreg", mwreg, 0);
        chk("b2b_ld2_req", dmem.req, 1);
        chk("b2b_ld2_addr", dmem.addr, 32'h104);
        step();
        chk("b2b_w3_wvalid", wvalid, 1);
        chk("b2b_w3_wrn", wrn, 12);
        chk("b2b_w3_wdata", wdata, 32'h33334444);
        chk("b2b_w3_wwreg", wwreg, 1);
        step();
        chk("b2b_end_wvalid", wvalid, 0);
        chk("b2b_end_req", dmem.req, 0);

        // Reset during the second wait cycle of a load
        dmem.ready = 1'b0;
        dmem.rdata = 32'h0;
        drive(1'b1, 32'h200, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
        step();
        idle_in();
        chk("rstb_wait1_stall", mstall, 1);
        step();
        chk("rstb_wait2_stall", mstall, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstb_req", dmem.req, 0);
        chk("rstb_stall", mstall, 0);
        chk("rstb_wvalid", wvalid, 0);
        dmem.ready = 1'b1;
        dmem.rdata = 32'h77777777;
        step();
        chk("rstb_after_wvalid", wvalid, 0);
        chk("rstb_after_req", dmem.req, 0);
        dmem.ready = 1'b0;
        step();

`ifdef MEM_MISALIGN_CHECK_EN
        // Misaligned load raises an exception writeback, no bus request
        drive(1'b1, 32'h42, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        step();
        idle_in();
        chk("mis_req", dmem.req, 0);
        chk("mis_stall", mstall, 0);
        chk("mis_m_wexc", wexc, 0);
        step();
        chk("mis_wvalid", wvalid, 1);
        chk("mis_wexc", wexc, 1);
        chk("mis_wwreg", wwreg, 0);
        chk("mis_req2", dmem.req, 0);
        step();
        chk("mis_after_wexc", wexc, 0);
        chk("mis_after_wvalid", wvalid, 0);
`else
        // Without the check the low address bits are dropped
        dmem.ready = 1'b1;
        dmem.rdata = 32'hCAFEF00D;
        drive(1'b1, 32'h43, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        step();
        idle_in();
        chk("mis_req", dmem.req, 1);
        chk("mis_addr", dmem.addr, 32'h40);
        chk("mis_malu", malu, 32'h43);
        step();
        chk("mis_wvalid", wvalid, 1);
        chk("mis_wdata", wdata, 32'hCAFEF00D);
        chk("mis_wwreg", wwreg, 1);
        dmem.ready = 1'b0;
`endif

        // Register 0 passes through unchanged
        drive(1'b1, 32'h9, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        idle_in();
        chk("r0_mwreg", mwreg, 1);
        step();
        chk("r0_wvalid", wvalid, 1);
        chk("r0_wrn", wrn, 0);
        chk("r0_wwreg", wwreg, 1);
        chk("r0_wdata", wdata, 32'h9);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
